// File: rtl/seq_add_pkg.sv
// Shared constants and state encoding for the sequential nibble accumulator feeder.
package seq_add_pkg;

    localparam int NIB_W   = 4;
    localparam int N_NIB   = 128;
    localparam int ACC_W   = 12;
    localparam int ACC_LAT = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feed_state_t;

endpackage

// File: rtl/nib_shift_reg.sv
// Frame-wide shift register: parallel load, shift right one nibble per enabled cycle,
// lowest nibble exposed as the next nibble to present.
module nib_shift_reg #(
    parameter int N_NIB = 128,
    parameter int NIB_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     shift,
    input  logic [N_NIB*NIB_W-1:0]   din,
    output logic [NIB_W-1:0]         nib
);

    localparam int SR_W = N_NIB * NIB_W;

    logic [SR_W-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {{NIB_W{1'b0}}, sr[SR_W-1:NIB_W]};
        end
    end

    assign nib = sr[NIB_W-1:0];

endmodule

// File: rtl/seq_add_feeder.sv
// Captures a nibble frame on start and streams it, one nibble per clock, into an
// always-adding accumulator; flags the cycle the accumulator sum covers the whole frame.
module seq_add_feeder #(
    parameter int N_NIB   = seq_add_pkg::N_NIB,
    parameter int NIB_W   = seq_add_pkg::NIB_W,
    parameter int ACC_LAT = seq_add_pkg::ACC_LAT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_NIB*NIB_W-1:0]      arr_in,
    input  logic [NIB_W-1:0]            mask_in,
    output logic [NIB_W-1:0]            nib_out,
    output logic [NIB_W-1:0]            check_out,
    output logic                        busy,
    output logic                        sum_valid,
    output logic [$clog2(N_NIB)-1:0]    nib_idx
);

    import seq_add_pkg::*;

    localparam int IDX_W = $clog2(N_NIB);
    localparam int DRN_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NIB - 1);
    // DRAIN lasts ACC_LAT-1 cycles; the counter counts down to zero inclusive.
    localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(ACC_LAT - 2);

    feed_state_t       state, state_d;
    logic [IDX_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx_d;
    logic              last_q, last_d;
    logic [DRN_W-1:0]  drn_q, drn_d;
    logic [NIB_W-1:0]  mask_q, mask_d;
    logic [NIB_W-1:0]  nib_d, chk_d;
    logic [NIB_W-1:0]  sr_nib;
    logic              busy_d, sv_d;
    logic              load, shift;

    nib_shift_reg #(
        .N_NIB (N_NIB),
        .NIB_W (NIB_W)
    ) u_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .din   (arr_in),
        .nib   (sr_nib)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_q    <= 1'b0;
            drn_q     <= '0;
            mask_q    <= '0;
            nib_out   <= '0;
            check_out <= '0;
            nib_idx   <= '0;
            busy      <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            last_q    <= last_d;
            drn_q     <= drn_d;
            mask_q    <= mask_d;
            nib_out   <= nib_d;
            check_out <= chk_d;
            nib_idx   <= idx_d;
            busy      <= busy_d;
            sum_valid <= sv_d;
        end
    end

    // Next-state and next-output values; every output is registered above.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last_d  = last_q;
        drn_d   = drn_q;
        mask_d  = mask_q;
        nib_d   = '0;
        idx_d   = '0;
        chk_d   = check_out;
        busy_d  = busy;
        sv_d    = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;

        case (state)
            IDLE: begin
                chk_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    load    = 1'b1;
                    mask_d  = mask_in;
                    chk_d   = mask_in;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = STREAM;
                end
            end

            STREAM: begin
                chk_d = mask_q;
                if (last_q) begin
                    // Final nibble already presented; hold zero while the accumulator catches up.
                    state_d = DRAIN;
                    drn_d   = DRN_INIT;
                end else begin
                    nib_d = sr_nib;
                    idx_d = cnt;
                    shift = 1'b1;
                    cnt_d = cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        last_d = 1'b1;
                    end
                end
            end

            DRAIN: begin
                if (drn_q == '0) begin
                    state_d = IDLE;
                    sv_d    = 1'b1;
                    busy_d  = 1'b0;
                    chk_d   = '0;
                end else begin
                    drn_d = drn_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                chk_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/seq_add_feeder.md
# seq_add_feeder

Upstream stage of the sequential nibble accumulator: captures a 512-bit array (128 × 4-bit nibbles) plus a 4-bit check mask on `start`, then presents one nibble per clock on the accumulator's `arr`/`in_check` inputs. The accumulator adds every cycle and has no enable, so this block drives zero whenever no frame is active. It pulses `sum_valid` in the cycle the accumulator output first includes the whole frame.

## Interface
- `N_NIB`, 128, nibbles per frame.
- `NIB_W`, 4, nibble width.
- `ACC_LAT`, 2, accumulator latency in clocks from a nibble on `nib_out` to its inclusion in the sum.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `arr_in`  in  N_NIB*NIB_W  frame data; nibble k = `arr_in[4k+3:4k]`.
- `mask_in`  in  NIB_W  check mask for the frame.
- `nib_out`  out  NIB_W  nibble to accumulator `arr`.
- `check_out`  out  NIB_W  mask to accumulator `in_check`.
- `busy`  out  1  frame in progress.
- `sum_valid`  out  1  one-cycle pulse: accumulator output includes the full frame.
- `nib_idx`  out  7  index of the nibble currently on `nib_out`; debug and verification only.

## Operation
- States: IDLE, STREAM, DRAIN.
- **IDLE**
  - `nib_out` = 0, `check_out` = 0, `busy` = 0.
  - `start` = 1 at edge E0: capture `arr_in` into an internal shift register and `mask_in` into a mask register; go to STREAM.
- **STREAM**
  - After edge E(k+1), k = 0..N_NIB-1: `nib_out` = nibble k, `nib_idx` = k, `check_out` = captured mask.
  - Shift right by NIB_W each cycle; a 7-bit counter tracks k.
  - When k = N_NIB-1 has been presented, go to DRAIN.
- **DRAIN**
  - `nib_out` = 0; `check_out` holds the mask.
  - Wait ACC_LAT-1 cycles, then return to IDLE with `sum_valid` = 1 for exactly one cycle.
- `start` is ignored while `busy` = 1. No queuing, no error flag.
- The accumulator is cumulative across frames; this block never clears it. Only `rst` clears it.
- Width rule: the maximum frame sum is 128 × 15 = 1920, which fits the 12-bit accumulator. Back-to-back frames can wrap modulo 4096. This is accepted, and the consumer must handle it.
- Reset (any time, including mid-frame):
  - State → IDLE.
  - `nib_out`, `check_out`, `nib_idx`, `sum_valid`, `busy` → 0.
  - Shift register and mask register → 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- For `start` at E0:
  - `busy` = 1 after E0.
  - Nibble 0 is on `nib_out` after E1; nibble 127 after E128.
  - DRAIN after E129.
  - After E130: `sum_valid` = 1, `busy` = 0, state IDLE.
  - After E131: `sum_valid` = 0.
- Accumulator alignment: it registers `b` at E(k+2) and adds into `a` at E(k+3). Nibble 127 is therefore in `out` after E130, the same cycle `sum_valid` is high.
- A new `start` sampled at E130 is not accepted, because the state is still DRAIN. The earliest accepted `start` is at E131; its nibble 0 appears after E132.

## Structure
- Package `seq_add_pkg` holds:
  - Constants `NIB_W` = 4, `N_NIB` = 128, `ACC_W` = 12, `ACC_LAT` = 2.
  - State enum `feed_state_t` {IDLE, STREAM, DRAIN}.
- Sub-module `nib_shift_reg`:
  - Parallel load, shift right by NIB_W, low nibble as output.
  - Keeps the FSM and counter logic separate from the 512-bit datapath.
- The top level of the test bench instantiates `seq_add_feeder` driving the existing accumulator.

## Test plan
- Reset, then all nibbles 0xF, mask 0xF, `start` at E0 → `sum_valid` after E130 with accumulator `out` = 0x780 (1920); `busy` high for exactly 130 cycles.
- Nibble k = k mod 16, mask 0xF → `out` = 960 when `sum_valid`; `nib_idx` matches `nib_out` on every STREAM cycle.
- Same data, mask 0x1 → `out` = 64; `check_out` = 0x1 throughout STREAM and DRAIN, and 0 in IDLE.
- `start` pulsed again at E60 and at E130 → both ignored; exactly one `sum_valid`. `start` at E131 → second frame accepted; the all-0xF case gives cumulative `out` = 3840.
- `rst` asserted after nibble 50 → all outputs 0 immediately (asynchronous), no `sum_valid`, state IDLE; a new frame after release produces the correct sum from zero.
- `start` held low for 200 cycles after reset → `nib_out` = 0 throughout and accumulator `out` stays 0.
